// File: rtl/gate_pkg.sv
// Shared types and helpers for the debounced gate array: mode encoding,
// the per-channel gate function and the default debounce length.
package gate_pkg;

    typedef enum logic [1:0] {
        MODE_AND  = 2'b00,
        MODE_OR   = 2'b01,
        MODE_XOR  = 2'b10,
        MODE_NAND = 2'b11
    } gate_mode_t;

    // 10 ms at 100 MHz
    localparam int DB_CYCLES_DEF = 1000000;

    function automatic logic gate_op(input gate_mode_t mode, input logic a, input logic b);
        logic r;
        case (mode)
            MODE_AND:  r = a & b;
            MODE_OR:   r = a | b;
            MODE_XOR:  r = a ^ b;
            MODE_NAND: r = ~(a & b);
            default:   r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/debounce_sync.sv
// Two-flop synchroniser followed by a hold-time debouncer: a new level is
// accepted only after it has been seen for DB_CYCLES consecutive cycles.
module debounce_sync #(
    parameter int DB_CYCLES = 1000000,
    parameter int CNT_W     = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic stable
);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_stable;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_stable <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_sync1 <= raw;
            r_sync2 <= r_sync1;
            // Any edge where the level agrees with stable restarts the count.
            if (r_sync2 == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_W'(DB_CYCLES - 1)) begin
                r_stable <= r_sync2;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign stable = r_stable;

endmodule

// File: rtl/debounced_gate_array.sv
// N_CH switch-driven two-input gates with a button-selected gate mode;
// all raw inputs are synchronised and debounced, all outputs registered.
module debounced_gate_array
    import gate_pkg::*;
#(
    parameter int N_CH      = 4,
    parameter int DB_CYCLES = DB_CYCLES_DEF,
    parameter int CNT_W     = 20
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [2*N_CH-1:0] swt,
    input  logic              btn_mode,
    output logic [N_CH-1:0]   led,
    output logic              led_all,
    output logic [1:0]        mode_led
);

    localparam int N_IN = 2 * N_CH + 1;

    logic [N_IN-1:0] w_raw;
    logic [N_IN-1:0] w_stable;
    logic            w_btn_rise;
    logic [N_CH-1:0] w_res;
    gate_mode_t      w_mode_nxt;

    gate_mode_t      r_mode;
    logic            r_btn_d;
    logic [N_CH-1:0] r_led;
    logic            r_led_all;

    // Button occupies the top debouncer slot, switches the rest.
    assign w_raw = {btn_mode, swt};

    for (genvar g = 0; g < N_IN; g++) begin : g_db
        debounce_sync #(
            .DB_CYCLES(DB_CYCLES),
            .CNT_W    (CNT_W)
        ) u_db (
            .clk   (clk),
            .rst_n (rst_n),
            .raw   (w_raw[g]),
            .stable(w_stable[g])
        );
    end

    assign w_btn_rise = w_stable[N_IN-1] & ~r_btn_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode  <= MODE_AND;
            r_btn_d <= 1'b0;
        end else begin
            r_mode  <= w_mode_nxt;
            r_btn_d <= w_stable[N_IN-1];
        end
    end

    always_comb begin
        w_mode_nxt = r_mode;
        if (w_btn_rise) begin
            case (r_mode)
                MODE_AND:  w_mode_nxt = MODE_OR;
                MODE_OR:   w_mode_nxt = MODE_XOR;
                MODE_XOR:  w_mode_nxt = MODE_NAND;
                MODE_NAND: w_mode_nxt = MODE_AND;
                default:   w_mode_nxt = MODE_AND;
            endcase
        end
    end

    always_comb begin
        w_res = '0;
        for (int i = 0; i < N_CH; i++) begin
            w_res[i] = gate_op(r_mode, w_stable[2*i], w_stable[2*i+1]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_led     <= '0;
            r_led_all <= 1'b0;
        end else begin
            r_led     <= w_res;
            r_led_all <= &w_res;
        end
    end

    assign led      = r_led;
    assign led_all  = r_led_all;
    assign mode_led = r_mode;

endmodule

// File: tb/tb_debounced_gate_array.sv
// Directed bench for debounced_gate_array with a short debounce window.
module tb_debounced_gate_array;

    localparam int N_CH      = 4;
    localparam int DB_CYCLES = 4;
    localparam int CNT_W     = 3;

    logic              clk;
    logic              rst_n;
    logic [2*N_CH-1:0] swt;
    logic              btn_mode;
    logic [N_CH-1:0]   led;
    logic              led_all;
    logic [1:0]        mode_led;

    int n_tests = 0;
    int n_fail  = 0;

    debounced_gate_array #(
        .N_CH     (N_CH),
        .DB_CYCLES(DB_CYCLES),
        .CNT_W    (CNT_W)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .swt     (swt),
        .btn_mode(btn_mode),
        .led     (led),
        .led_all (led_all),
        .mode_led(mode_led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [3:0] e_led,
                             input logic e_all, input logic [1:0] e_mode);
        check({tag, ".led"}, 8'(led), 8'(e_led));
        check({tag, ".led_all"}, 8'(led_all), 8'(e_all));
        check({tag, ".mode"}, 8'(mode_led), 8'(e_mode));
    endtask

    // One clean button press: high for 10 cycles, low for 10 cycles.
    task automatic press;
        btn_mode = 1'b1;
        tick(10);
        btn_mode = 1'b0;
        tick(10);
    endtask

    initial begin
        rst_n    = 1'b0;
        swt      = '0;
        btn_mode = 1'b0;

        // 1: reset state, then idle hold after release
        tick(3);
        check_out("rst", 4'b0000, 1'b0, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;
        tick(1);
        for (int i = 0; i < 20; i++) begin
            check_out("idle", 4'b0000, 1'b0, 2'b00);
            tick(1);
        end

        // 2: latency of an accepted switch change
        swt = 8'hFF;
        tick(6);
        check_out("lat_e5", 4'b0000, 1'b0, 2'b00);
        tick(1);
        check_out("lat_e6", 4'b1111, 1'b1, 2'b00);

        // 3: 3-cycle glitch is rejected
        swt[0] = 1'b0;
        tick(3);
        swt[0] = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            check("glitch.led", 8'(led), 8'hF);
        end
        // A later genuine change still needs the full window
        swt[0] = 1'b0;
        tick(6);
        check("glitch2_e5", 8'(led), 8'hF);
        tick(1);
        check("glitch2_e6", 8'(led), 8'hE);
        check("glitch2_all", 8'(led_all), 8'h0);

        // 4: mode stepping with alternating channel pairs
        swt = 8'b0110_0110;
        tick(10);
        check_out("and0", 4'b0000, 1'b0, 2'b00);
        press();
        check_out("or", 4'b1111, 1'b1, 2'b01);
        press();
        check_out("xor", 4'b1111, 1'b1, 2'b10);
        press();
        check_out("nand", 4'b1111, 1'b1, 2'b11);
        press();
        check_out("and1", 4'b0000, 1'b0, 2'b00);

        // 5: held button gives exactly one advance
        btn_mode = 1'b1;
        tick(6);
        check("hold_e5", 8'(mode_led), 8'h0);
        tick(1);
        check("hold_e6", 8'(mode_led), 8'h1);
        check("hold_e6.led", 8'(led), 8'h0);
        tick(1);
        check("hold_e7.led", 8'(led), 8'hF);
        tick(43);
        check_out("hold50", 4'b1111, 1'b1, 2'b01);
        btn_mode = 1'b0;
        tick(20);
        check_out("release", 4'b1111, 1'b1, 2'b01);

        // 6: asynchronous reset mid-count, then full re-acceptance
        swt = 8'hFF;
        tick(10);
        check_out("pre_rst", 4'b1111, 1'b1, 2'b01);
        swt = 8'h00;
        tick(3);
        #2;
        rst_n = 1'b0;
        #1;
        check_out("async_rst", 4'b0000, 1'b0, 2'b00);
        swt = 8'hFF;
        tick(2);
        check_out("in_rst", 4'b0000, 1'b0, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;
        tick(6);
        check_out("rel_e5", 4'b0000, 1'b0, 2'b00);
        tick(1);
        check_out("rel_e6", 4'b1111, 1'b1, 2'b00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
